// File: rtl/npu_csr_axil_slave_pkg.sv
// Shared definitions for the NPU CSR block: register offsets, AXI response
// codes, status bit positions and the offset decoder used by both the write
// and read paths.
package npu_csr_pkg;

  localparam int NUM_CFG = 9;

  localparam logic [7:0] CSR_CMD    = 8'h00;
  localparam logic [7:0] CSR_CFG0   = 8'h04;
  localparam logic [7:0] CSR_STATUS = 8'h28;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum int {
    STAT_BUSY = 0,
    STAT_DONE = 1
  } status_bit_e;

  typedef enum logic [1:0] {
    SEL_CMD,
    SEL_CFG,
    SEL_STATUS,
    SEL_NONE
  } csr_sel_e;

  // Only word-aligned offsets inside the map are valid; everything else errors.
  function automatic csr_sel_e csr_decode(input logic [7:0] off);
    if (off == CSR_CMD) return SEL_CMD;
    if (off == CSR_STATUS) return SEL_STATUS;
    if (off >= CSR_CFG0 && off < CSR_CFG0 + 8'(NUM_CFG * 4) && off[1:0] == 2'b00)
      return SEL_CFG;
    return SEL_NONE;
  endfunction

  function automatic logic [3:0] cfg_index(input logic [7:0] off);
    return 4'((off - CSR_CFG0) >> 2);
  endfunction

endpackage

// File: rtl/npu_csr_axil_slave_if.sv
// AXI4-Lite bus bundle between the host CSR master and the NPU CSR slave.
interface npu_csr_axil_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/npu_csr_axil_slave_holder.sv
// One-entry holding register for an AXI-Lite write channel (AW or W).
// Accepts one beat when empty and not blocked, keeps it until cleared.
module axil_wr_holder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         block,
  input  logic         clr,
  output logic         ready,
  output logic         full,
  output logic [W-1:0] data
);

  assign ready = !full && !block && !rst;

  // Occupancy flag: set on handshake, dropped on commit or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= 1'b0;
    else if (clr) full <= 1'b0;
    else if (in_valid && ready) full <= 1'b1;
  end

  // Payload capture; only meaningful while full is set.
  always_ff @(posedge clk) begin
    if (in_valid && ready) data <= in_data;
  end

endmodule

// File: rtl/npu_csr_axil_slave.sv
// AXI4-Lite CSR slave for the NPU: command word with start strobe, config
// words, and a busy/done status with level interrupt.
module npu_csr_axil_slave
  import npu_csr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  npu_csr_axil_slave_if.slave           s_axi,
  output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_o,
  output logic [DATA_WIDTH-1:0]         cmd_o,
  output logic                          cmd_start_o,
  input  logic                          compute_done_i,
  output logic                          busy_o,
  output logic                          irq_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  aw_full, w_full, commit;
  logic [7:0]            aw_off;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  bvalid_q, rvalid_q, busy_q, done_q;
  logic [1:0]            bresp_q, rresp_q, rd_resp;
  logic [DATA_WIDTH-1:0] rdata_q, rd_data, cmd_q;
  logic [DATA_WIDTH-1:0] cfg_q [NUM_CFG];
  csr_sel_e              wr_sel, rd_sel;
  logic                  cmd_blocked, wr_ok, cmd_accept, done_w1c;
  logic                  unused_bits;

  function automatic logic [DATA_WIDTH-1:0] strb_merge(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  axil_wr_holder #(.W(8)) u_aw_hold (
    .clk(clk), .rst(rst), .in_valid(s_axi.awvalid), .in_data(s_axi.awaddr[7:0]),
    .block(bvalid_q), .clr(commit), .ready(s_axi.awready), .full(aw_full), .data(aw_off)
  );

  axil_wr_holder #(.W(DATA_WIDTH + STRB_W)) u_w_hold (
    .clk(clk), .rst(rst), .in_valid(s_axi.wvalid), .in_data({s_axi.wstrb, s_axi.wdata}),
    .block(bvalid_q), .clr(commit), .ready(s_axi.wready), .full(w_full), .data({w_strb, w_data})
  );

  assign commit      = aw_full && w_full;
  assign wr_sel      = csr_decode(aw_off);
  assign cmd_blocked = (wr_sel == SEL_CMD) && busy_q;
  assign wr_ok       = commit && (wr_sel != SEL_NONE) && !cmd_blocked;
  assign cmd_accept  = wr_ok && (wr_sel == SEL_CMD);
  assign done_w1c    = wr_ok && (wr_sel == SEL_STATUS) && w_strb[0] && w_data[STAT_DONE];

  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.arready = !rvalid_q && !rst;
  assign cmd_o         = cmd_q;
  assign busy_o        = busy_q;
  assign irq_o         = done_q;
  assign unused_bits   = ^{s_axi.awaddr[ADDR_WIDTH-1:8], s_axi.araddr[ADDR_WIDTH-1:8],
                           s_axi.awprot, s_axi.arprot};

  // Write response: raised on commit, held until the host takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= (wr_sel != SEL_NONE && !cmd_blocked) ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi.bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Register file update with byte-strobe merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= '0;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else if (wr_ok) begin
      if (wr_sel == SEL_CMD) cmd_q <= strb_merge(cmd_q, w_data, w_strb);
      if (wr_sel == SEL_CFG)
        cfg_q[cfg_index(aw_off)] <= strb_merge(cfg_q[cfg_index(aw_off)], w_data, w_strb);
    end
  end

  // Start strobe and busy/done tracking; a done event beats a same-cycle W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_start_o <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cmd_start_o <= cmd_accept;
      if (busy_q && compute_done_i) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        if (cmd_start_o) busy_q <= 1'b1;
        if (cmd_accept || done_w1c) done_q <= 1'b0;
      end
    end
  end

  // Read mux on the incoming AR address.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    rd_sel  = csr_decode(s_axi.araddr[7:0]);
    case (rd_sel)
      SEL_CMD:    rd_data = cmd_q;
      SEL_CFG:    rd_data = cfg_q[cfg_index(s_axi.araddr[7:0])];
      SEL_STATUS: begin
        rd_data[STAT_BUSY] = busy_q;
        rd_data[STAT_DONE] = done_q;
      end
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  // Read response register: captured on AR handshake, held until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (s_axi.arvalid && s_axi.arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Config word packing onto the flat output bus.
  always_comb begin
    cfg_o = '0;
    for (int i = 0; i < NUM_CFG; i++) cfg_o[i*DATA_WIDTH +: DATA_WIDTH] = cfg_q[i];
  end

endmodule

// File: doc/npu_csr_axil_slave.md
Name: npu_csr_axil_slave

Overview:
- AXI4-Lite responder (slave) holding the accelerator's control/status registers.
- Sits between the host CSR bus and the NPU datapath controller.
- Exports nine 32-bit config words and a command word with a one-cycle start strobe.
- Tracks busy/done and raises a level interrupt when computation completes.

Parameters:
- ADDR_WIDTH, `CSR_ADDR_WIDTH, AXI address width; only addr[7:0] is decoded, upper bits are ignored (base 0x4000_0000 aliases).
- DATA_WIDTH, `DATA_WIDTH (32), AXI data and register width.
- NUM_CFG, 9, number of config registers at 0x04..0x24.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- s_axi_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  write-address channel; awprot is ignored.
- s_axi_awready  out  1  write-address ready.
- s_axi_wdata/wstrb/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1  write-data channel.
- s_axi_wready  out  1  write-data ready.
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1  write-response channel.
- s_axi_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1 / s_axi_arready  out  1  read-address channel.
- s_axi_rdata  out  DATA_WIDTH / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1  read-data channel.
- cfg_o  out  NUM_CFG*DATA_WIDTH  config words, cfg[i] at bits [32i+31:32i].
- cmd_o  out  DATA_WIDTH  last accepted command word.
- cmd_start_o  out  1  one-cycle pulse on command acceptance.
- compute_done_i  in  1  level or pulse from the datapath; the rising edge is not required.
- busy_o  out  1  command in flight.
- irq_o  out  1  done interrupt (level).

Behaviour:
- Register map:
  - 0x00 CMD (R/W).
  - 0x04+4i CFG[i], i=0..8 (R/W).
  - 0x28 STATUS (R; bit0=busy, bit1=done; W1C on bit1).
  - Any other offset is unmapped.
- Reset: all registers 0; awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; cmd_start_o=0; busy_o=0; irq_o=0.
- Write address channel:
  - AW and W are independent. Each has a one-entry holding register.
  - awready=1 while the AW holder is empty and bvalid=0. wready follows the same rule using the W holder.
  - AW may precede W by any number of cycles, and vice versa; the host sends AW then W.
- Write commit:
  - Occurs in the cycle after both holders are full. The register is updated per byte via wstrb.
  - bvalid rises the same cycle as the update, i.e. write latency is 1 clk after the later of the AW/W handshakes.
  - Both holders clear on commit. bvalid holds until bready; the next AW/W is not accepted until the B handshake completes.
- bresp values:
  - OKAY (00) for mapped offsets.
  - SLVERR (10) for unmapped offsets; no state change.
  - SLVERR for a CMD write while busy_o=1; the register and pulse are suppressed.
- CMD write accepted (busy=0):
  - cmd_o takes the new value (strobe-merged).
  - cmd_start_o=1 for exactly the commit cycle.
  - busy_o=1 from the next cycle.
  - The done bit clears on the commit cycle.
- compute_done_i=1 while busy_o=1: busy_o clears next cycle; done sets; irq_o=done.
  - compute_done_i while not busy is ignored.
  - Done set and W1C in the same cycle: set wins.
- Read channel:
  - arready=1 when rvalid=0 and no read is latched.
  - On the AR handshake, rdata/rresp are registered and rvalid=1 on the next cycle, giving 1-cycle read latency.
  - rvalid holds with stable data until rready.
  - Unmapped read: rdata=0, rresp=SLVERR.
  - Reads and writes proceed concurrently; a read of a register written in the same cycle returns the old value.
- Reset mid-transaction: all pending handshakes and holders are dropped; busy is cleared; no cmd_start pulse is emitted.

Decomposition:
- Shared package npu_csr_pkg:
  - Offsets CSR_CMD=8'h00, CSR_CFG0=8'h04, CSR_STATUS=8'h28.
  - NUM_CFG.
  - AXI resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - A status-bit enum.
- One natural sub-module: axil_wr_holder, a one-entry skid/hold register instantiated for AW and for W.

Test Plan:
- Reset then read 0x04..0x24 and 0x28 -> every rdata=0, rresp=OKAY, rvalid exactly one clk after the AR handshake.
- Write 0x4000_0004=0x4200_0000 … 0x4000_0024=15 (AW first, W 1 clk later) -> bresp=OKAY; readback returns identical values; cfg_o slice 8 = 15.
- Write 0x4000_0000=0x0302_FFE1 -> cmd_start_o pulses 1 clk in the bvalid-rise cycle; cmd_o=0x0302_FFE1; STATUS reads 0x1.
- While busy, write CMD=0x1234 -> bresp=SLVERR, cmd_o unchanged, no pulse. Then drive compute_done_i for 1 clk -> busy_o=0, irq_o=1, STATUS=0x2. Write STATUS=0x2 -> irq_o=0.
- Write with wstrb=4'b0010, wdata=0xAABB_CCDD to CFG0 holding 0x4200_0000 -> CFG0=0x4200_CC00. Write/read 0x4000_0040 -> SLVERR, read data 0.
- Hold bready=0 for 5 clks after a write -> bvalid stays 1 and awready/wready stay 0. Assert rst mid-hold -> bvalid=0 and awready=0 during reset; all registers read 0 afterwards.
